run_controller: RTL and testbench

Host-facing sequencer for the processor core. It loads a program into instruction memory over a valid/ready stream and holds the core in reset while it does so. It then releases the core, runs it until the program halts or a cycle budget is exhausted, and reports completion and the cycle count. It sits between the host/testbench and the core, and drives the core reset plus the instruction-memory write port.

---
 rtl/run_controller_if.sv | 30 +++
 rtl/run_controller.sv | 192 +++++++++++++++++++
 tb/tb_run_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - host load stream and instruction-memory write port bundle
//
// Signals:
//   load_valid/load_ready/load_data/load_last : program word stream, host -> controller
//   imem_we/imem_addr/imem_wdata              : instruction memory write port, controller -> memory
// Modports:
//   master : host side (drives the load stream, observes the write port)
//   slave  : controller side
interface run_controller_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               load_valid;
    logic               load_ready;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;
    logic               imem_we;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        output load_valid, load_data, load_last,
        input  load_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  load_valid, load_data, load_last,
        output load_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/run_controller.sv
// rtl/run_controller.sv - program loader and run sequencer for the processor core
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   bus (slave)              : load stream in, instruction memory write port out
//   start, abort             : single-cycle run / stop requests
//   cycle_limit              : run budget, 0 = unlimited, captured when a start is accepted
//   core_rst                 : reset to the core, low only while running
//   program_counter,
//   next_program_counter     : core PCs, equal values mean the program jumped to itself
//   busy, done, halted       : status; halted qualifies done
//   load_err                 : last load ran past the top of instruction memory
//   cycles                   : RUN cycles of the current or last run, saturating
module run_controller #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int CYC_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    run_controller_if.slave  bus,
    input  logic             start,
    input  logic             abort,
    input  logic [CYC_W-1:0] cycle_limit,
    output logic             core_rst,
    input  logic [PC_W-1:0]  program_counter,
    input  logic [PC_W-1:0]  next_program_counter,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             load_err,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Highest even address; a word accepted here without load_last overflows.
    localparam logic [PC_W-1:0] TOP_ADDR = ~PC_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [PC_W-1:0]    wr_addr;
    logic [CYC_W-1:0]   limit_q;
    logic [CYC_W-1:0]   cycles_q;
    logic               done_q;
    logic               halted_q;
    logic               load_err_q;

    logic               load_ready_c;
    logic               accept;
    logic               start_ok;
    logic               at_top;
    logic               halt_hit;
    logic               limit_hit;
    logic               run_exit;
    logic [CYC_W:0]     cycles_inc;
    logic [INSTR_W-1:0] wdata;

    assign accept     = bus.load_valid & load_ready_c;
    // A word accepted in the same cycle takes precedence over start.
    assign start_ok   = start & ~accept & ((state == S_IDLE) | (state == S_DONE));
    assign at_top     = (wr_addr == TOP_ADDR);
    assign halt_hit   = (next_program_counter == program_counter);
    // One bit wider so the limit compare and the saturation test share the sum.
    assign cycles_inc = {1'b0, cycles_q} + (CYC_W+1)'(1);
    assign limit_hit  = (limit_q != '0) && (cycles_inc == {1'b0, limit_q});
    assign run_exit   = abort | halt_hit | limit_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = bus.load_last ? S_IDLE : S_LOAD;
                end else if (start) begin
                    state_nxt = S_PRIME;
                end
            end
            S_LOAD: begin
                if (accept && (bus.load_last || at_top)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PRIME: state_nxt = S_RUN;
            S_RUN: begin
                if (run_exit) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        core_rst     = 1'b1;
        load_ready_c = 1'b0;
        busy         = 1'b0;
        unique case (state)
            S_IDLE:  load_ready_c = 1'b1;
            S_LOAD: begin
                load_ready_c = 1'b1;
                busy         = 1'b1;
            end
            S_PRIME: busy = 1'b1;
            S_RUN: begin
                core_rst = 1'b0;
                busy     = 1'b1;
            end
            S_DONE:  load_ready_c = 1'b1;
            default: load_ready_c = 1'b0;
        endcase
    end

    assign wdata          = bus.load_data;
    assign bus.load_ready = load_ready_c;
    assign bus.imem_we    = accept;
    assign bus.imem_addr  = wr_addr;
    assign bus.imem_wdata = wdata;

    // Address, status and cycle counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr    <= '0;
            limit_q    <= '0;
            cycles_q   <= '0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (accept) begin
                // wr_addr is 0 outside LOAD, so the first word lands at 0 and
                // the next one at 2; any exit from LOAD returns it to 0.
                wr_addr <= (state_nxt == S_LOAD) ? wr_addr + PC_W'(2) : '0;
            end

            if (accept && (state != S_LOAD)) begin
                load_err_q <= 1'b0;
            end else if (accept && at_top && !bus.load_last) begin
                load_err_q <= 1'b1;
            end

            if (accept && (state == S_DONE)) begin
                done_q   <= 1'b0;
                halted_q <= 1'b0;
            end

            if (start_ok) begin
                limit_q  <= cycle_limit;
                done_q   <= 1'b0;
                halted_q <= 1'b0;
            end

            if (state == S_PRIME) begin
                cycles_q <= '0;
                done_q   <= 1'b0;
                halted_q <= 1'b0;
            end

            if (state == S_RUN) begin
                cycles_q <= cycles_inc[CYC_W] ? cycles_q : cycles_inc[CYC_W-1:0];
                if (run_exit) begin
                    done_q   <= 1'b1;
                    // abort outranks a simultaneous halt
                    halted_q <= ~abort & halt_hit;
                end
            end
        end
    end

    assign done     = done_q;
    assign halted   = halted_q;
    assign load_err = load_err_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - self-checking bench for run_controller
module tb_run_controller;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int CYC_W   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CYC_W-1:0] cycle_limit = '0;
    logic [PC_W-1:0]  pc = '0;
    logic [PC_W-1:0]  npc = 8'd2;
    logic             core_rst, busy, done, halted, load_err;
    logic [CYC_W-1:0] cycles;

    logic             core_rst4, busy4, done4, halted4, load_err4;
    logic [CYC_W-1:0] cycles4;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] wq[$];

    run_controller_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
    run_controller_if #(.PC_W(4), .INSTR_W(INSTR_W)) bus4 ();

    run_controller #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .start(start), .abort(abort), .cycle_limit(cycle_limit),
        .core_rst(core_rst),
        .program_counter(pc), .next_program_counter(npc),
        .busy(busy), .done(done), .halted(halted), .load_err(load_err),
        .cycles(cycles)
    );

    run_controller #(.PC_W(4), .INSTR_W(INSTR_W), .CYC_W(CYC_W)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .start(1'b0), .abort(1'b0), .cycle_limit(32'd0),
        .core_rst(core_rst4),
        .program_counter(4'd0), .next_program_counter(4'd2),
        .busy(busy4), .done(done4), .halted(halted4), .load_err(load_err4),
        .cycles(cycles4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random with start/abort noise
    task automatic do_load(input string tag, input int mode, input bit with_last);
        int sent = 0;
        int cyc  = 0;
        bit v;
        while (sent < wq.size()) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1) || (cyc % 3 == 2);
            endcase
            bus.load_valid = v;
            bus.load_data  = v ? wq[sent] : 16'($urandom);
            bus.load_last  = with_last && (sent == wq.size() - 1);
            start = (mode == 2) && (v || sent > 0) && ($urandom_range(0, 1) == 1);
            abort = (mode == 2) && ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk({tag, " ready"}, 64'(bus.load_ready), 64'(1));
            chk({tag, " busy"}, 64'(busy), 64'(sent > 0));
            chk({tag, " we"}, 64'(bus.imem_we), 64'(v));
            if (v) begin
                chk({tag, " addr"}, 64'(bus.imem_addr), 64'(sent * 2));
                chk({tag, " wdata"}, 64'(bus.imem_wdata), 64'(wq[sent]));
            end
            tick();
            if (v) begin
                if (sent == 0) begin
                    chk({tag, " done clr"}, 64'(done), 64'(0));
                    chk({tag, " err clr"}, 64'(load_err), 64'(0));
                end
                sent++;
            end
            cyc++;
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk({tag, " end busy"}, 64'(busy), 64'(!with_last));
        if (with_last) chk({tag, " end addr"}, 64'(bus.imem_addr), 64'(0));
        tick();
    endtask

    // halt_at / abort_at are 1-based RUN cycle numbers, 0 = never
    task automatic do_run(input string tag, input int lim, input int halt_at, input int abort_at);
        int ea, eh, el, n;
        bit h;
        ea = (abort_at > 0) ? abort_at : 1 << 30;
        eh = (halt_at > 0) ? halt_at : 1 << 30;
        el = (lim > 0) ? lim : 1 << 30;
        n  = ea;
        if (eh < n) n = eh;
        if (el < n) n = el;
        h  = (eh == n) && (ea != n);

        cycle_limit = 32'(lim);
        start = 1'b1;
        @(negedge clk);
        chk({tag, " T core_rst"}, 64'(core_rst), 64'(1));
        tick();
        start = 1'b0;
        @(negedge clk);
        chk({tag, " prime core_rst"}, 64'(core_rst), 64'(1));
        chk({tag, " prime busy"}, 64'(busy), 64'(1));
        tick();
        for (int i = 1; i <= n; i++) begin
            pc    = 8'($urandom);
            npc   = (i == halt_at) ? pc : pc + 8'd2;
            abort = (i == abort_at);
            @(negedge clk);
            chk({tag, " run core_rst"}, 64'(core_rst), 64'(0));
            chk({tag, " run cycles"}, 64'(cycles), 64'(i - 1));
            if (i == 1) chk({tag, " run done"}, 64'(done), 64'(0));
            tick();
        end
        abort = 1'b0;
        npc   = pc + 8'd2;
        @(negedge clk);
        chk({tag, " end core_rst"}, 64'(core_rst), 64'(1));
        chk({tag, " end done"}, 64'(done), 64'(1));
        chk({tag, " end halted"}, 64'(halted), 64'(h));
        chk({tag, " end cycles"}, 64'(cycles), 64'(n));
        chk({tag, " end busy"}, 64'(busy), 64'(0));
        tick();
    endtask

    initial begin
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.load_last   = 1'b0;
        bus4.load_valid = 1'b0;
        bus4.load_data  = '0;
        bus4.load_last  = 1'b0;

        repeat (2) tick();
        @(negedge clk);
        chk("rst core_rst", 64'(core_rst), 64'(1));
        chk("rst ready", 64'(bus.load_ready), 64'(1));
        chk("rst we", 64'(bus.imem_we), 64'(0));
        chk("rst addr", 64'(bus.imem_addr), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst halted", 64'(halted), 64'(0));
        chk("rst load_err", 64'(load_err), 64'(0));
        chk("rst cycles", 64'(cycles), 64'(0));
        tick();
        rst = 1'b0;

        wq.delete();
        wq.push_back(16'h1111);
        wq.push_back(16'h2222);
        wq.push_back(16'h3333);
        wq.push_back(16'h4444);
        do_load("load4", 0, 1'b1);
        chk("load4 err", 64'(load_err), 64'(0));

        fill(6);
        do_load("alt", 1, 1'b1);
        fill(1);
        do_load("single", 0, 1'b1);

        do_run("lim10", 10, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("done held", 64'(done), 64'(1));
            chk("done ready", 64'(bus.load_ready), 64'(1));
            tick();
        end
        do_run("halt5", 0, 5, 0);
        do_run("abort3", 0, 0, 3);
        do_run("lim_eq_halt", 4, 4, 0);
        do_run("abort_eq_halt", 0, 2, 2);
        do_run("lim1", 1, 0, 0);

        fill(3);
        do_load("from_done", 2, 1'b1);

        // Overflow on the 16-address instance: 8 words fill 0..14, the 9th starts a new load.
        for (int i = 0; i < 9; i++) begin
            bus4.load_valid = 1'b1;
            bus4.load_data  = 16'(i * 257 + 1);
            bus4.load_last  = (i == 8);
            @(negedge clk);
            chk("ovf we", 64'(bus4.imem_we), 64'(1));
            chk("ovf addr", 64'(bus4.imem_addr), 64'((i * 2) % 16));
            chk("ovf wdata", 64'(bus4.imem_wdata), 64'(i * 257 + 1));
            chk("ovf busy", 64'(busy4), 64'(i >= 1 && i <= 7));
            if (i == 8) chk("ovf err set", 64'(load_err4), 64'(1));
            tick();
        end
        bus4.load_valid = 1'b0;
        bus4.load_last  = 1'b0;
        @(negedge clk);
        chk("ovf err clr", 64'(load_err4), 64'(0));
        chk("ovf idle", 64'(busy4), 64'(0));
        tick();

        // Reset in the middle of a load
        fill(3);
        do_load("part", 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstld busy", 64'(busy), 64'(0));
        chk("rstld addr", 64'(bus.imem_addr), 64'(0));
        chk("rstld ready", 64'(bus.load_ready), 64'(1));
        tick();
        rst = 1'b0;
        fill(2);
        do_load("after_rst", 0, 1'b1);

        // Reset in the middle of an unlimited run
        cycle_limit = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rstrun core_rst", 64'(core_rst), 64'(0));
        #1;
        rst = 1'b1;
        #1;
        chk("rstrun async core_rst", 64'(core_rst), 64'(1));
        chk("rstrun busy", 64'(busy), 64'(0));
        chk("rstrun cycles", 64'(cycles), 64'(0));
        tick();
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            int lim, ha, ab;
            fill($urandom_range(1, 8));
            do_load("rnd load", 2, 1'b1);
            lim = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            ha  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            if (lim == 0 && ha == 0 && ab == 0) lim = 7;
            do_run("rnd run", lim, ha, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
